// File: rtl/mem_burst_writer_pkg.sv
// Shared definitions for the MIG burst writer: instruction codes, state encoding
// and word geometry.
package mem_burst_writer_pkg;

  localparam logic [2:0] MIG_WRITE = 3'b000;
  localparam logic [2:0] MIG_READ  = 3'b001;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_PUSH  = 3'd2;
  localparam logic [2:0] ST_CMD   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    PUSH  = ST_PUSH,
    CMD   = ST_CMD,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE,
    ERR   = ST_ERR
  } state_t;

endpackage

// File: rtl/mem_burst_writer_byte_word_packer.sv
// Packs a byte stream big-endian into 32-bit words; a short final word gets
// its unfilled lanes masked off.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [3:0]  mask
);

  logic [1:0]  lane;
  logic [31:0] shift_reg;
  logic [4:0]  shamt;
  logic [31:0] word_next;

  // Lane 0 is the most significant byte, so the shift shrinks as lanes fill.
  assign shamt      = {2'd3 - lane, 3'b000};
  assign word_next  = shift_reg | ({24'd0, byte_data} << shamt);
  assign word_valid = byte_en && ((lane == 2'd3) || last);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane      <= 2'd0;
      shift_reg <= 32'd0;
      word      <= 32'd0;
      mask      <= 4'b0000;
    end else if (clear) begin
      lane      <= 2'd0;
      shift_reg <= 32'd0;
    end else if (byte_en) begin
      if (word_valid) begin
        word      <= word_next;
        mask      <= 4'b1111 >> ({1'b0, lane} + 3'd1);
        shift_reg <= 32'd0;
        lane      <= 2'd0;
      end else begin
        shift_reg <= word_next;
        lane      <= lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mem_burst_writer.sv
// Drives the MIG user write port from a byte producer: packs words, issues one
// write command per burst once its data is queued, then waits for the FIFO to drain.
module mem_burst_writer
  import mem_burst_writer_pkg::*;
#(
  parameter int          BURST_WORDS = 16,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int          TOTAL_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        done,
  output logic        error,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_full,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_full,
  input  logic        mem_wr_empty,
  input  logic        mem_wr_underrun,
  input  logic        mem_wr_error
);

  localparam int              BL_W       = $clog2(TOTAL_BYTES + 1);
  localparam logic [BL_W-1:0] BL_ONE     = BL_W'(1);
  localparam logic [BL_W-1:0] BL_TOTAL   = BL_W'(TOTAL_BYTES);
  localparam logic [6:0]      BURST_LAST = 7'(BURST_WORDS);

  state_t          state;
  logic [29:0]     addr;
  logic [BL_W-1:0] bytes_left;
  logic [6:0]      burst_cnt;

  logic byte_accept;
  logic word_valid;
  logic last_byte;
  logic mig_fault;
  logic start_xfer;
  logic burst_full;

  assign byte_accept   = byte_valid && byte_ready;
  assign last_byte     = (bytes_left == BL_ONE);
  assign mig_fault     = mem_wr_underrun || mem_wr_error;
  assign start_xfer    = start && ((state == IDLE) || (state == DONE));
  assign burst_full    = ((burst_cnt + 7'd1) == BURST_LAST);
  assign mem_cmd_instr = MIG_WRITE;
  assign mem_wr_en     = (state == PUSH) && !mem_wr_full;
  assign mem_cmd_en    = (state == CMD) && !mem_cmd_full;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_xfer),
    .byte_en    (byte_accept),
    .byte_data  (byte_data),
    .last       (last_byte),
    .word_valid (word_valid),
    .word       (mem_wr_data),
    .mask       (mem_wr_mask)
  );

  // MIG faults outrank every other transition; ERR is left only through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      byte_ready        <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      mem_cmd_bl        <= 6'd0;
      mem_cmd_byte_addr <= BASE_ADDR;
      addr              <= BASE_ADDR;
      bytes_left        <= '0;
      burst_cnt         <= 7'd0;
    end else if ((state != IDLE) && (state != ERR) && mig_fault) begin
      state      <= ERR;
      error      <= 1'b1;
      byte_ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FILL;
            byte_ready <= 1'b1;
            done       <= 1'b0;
            addr       <= BASE_ADDR;
            bytes_left <= BL_TOTAL;
            burst_cnt  <= 7'd0;
          end
        end
        FILL: begin
          if (byte_accept) begin
            bytes_left <= bytes_left - BL_ONE;
            if (word_valid) begin
              state      <= PUSH;
              byte_ready <= 1'b0;
            end
          end
        end
        PUSH: begin
          if (mem_wr_en) begin
            burst_cnt <= burst_cnt + 7'd1;
            if (burst_full || (bytes_left == '0)) begin
              state             <= CMD;
              mem_cmd_bl        <= 6'(burst_cnt);
              mem_cmd_byte_addr <= addr;
            end else begin
              state      <= FILL;
              byte_ready <= 1'b1;
            end
          end
        end
        CMD: begin
          if (mem_cmd_en) begin
            addr      <= addr + 30'(burst_cnt) * 30'(BYTES_PER_WORD);
            burst_cnt <= 7'd0;
            if (bytes_left != '0) begin
              state      <= FILL;
              byte_ready <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (mem_wr_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        ERR: begin
          byte_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_burst_writer.md
Name: mem_burst_writer

Overview:
- Controller that sequences the MIG user write port on behalf of a byte-stream producer, normally the SD card loader during boot.
- Packs incoming bytes into 32-bit words and pushes them into the MIG write-data FIFO.
- Issues one write command per burst, only after the whole burst's data is queued.
- Signals completion once TOTAL_BYTES have been committed and the write FIFO has drained.

Parameters:
- BURST_WORDS, 16: words per full burst, legal range 1..64.
- BASE_ADDR, 30'h0: byte address of the first word; must be 4-byte aligned.
- TOTAL_BYTES, 8192: bytes to transfer (64 Kib), legal range ≥1; need not be a multiple of 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a transfer
- byte_valid  in  1  producer byte available
- byte_data  in  8  producer byte
- byte_ready  out  1  byte accepted when byte_valid && byte_ready
- done  out  1  transfer complete, sticky
- error  out  1  MIG underrun or error seen, sticky
- mem_cmd_en  out  1  command strobe
- mem_cmd_instr  out  3  constant 3'b000 (write)
- mem_cmd_bl  out  6  burst length minus 1
- mem_cmd_byte_addr  out  30  burst start byte address
- mem_cmd_full  in  1  MIG command FIFO full
- mem_wr_en  out  1  write-data strobe
- mem_wr_mask  out  4  per-byte mask, 1 = byte not written
- mem_wr_data  out  32  write word
- mem_wr_full  in  1  MIG write FIFO full
- mem_wr_empty  in  1  MIG write FIFO empty
- mem_wr_underrun  in  1  MIG underrun flag
- mem_wr_error  in  1  MIG error flag

Behaviour:
- One clock, clk. Reset (rst) is synchronous and active-high.
- Reset values: state IDLE; byte_ready=0, done=0, error=0, mem_cmd_en=0, mem_wr_en=0, mem_wr_mask=0, mem_wr_data=0, mem_cmd_bl=0, mem_cmd_byte_addr=BASE_ADDR. All internal counters are cleared.
- States: IDLE, FILL, PUSH, CMD, DRAIN, DONE, ERR.
- IDLE:
  - start moves to FILL.
  - On entering FILL: addr=BASE_ADDR, bytes_left=TOTAL_BYTES, burst_cnt=0, done cleared.
- FILL:
  - byte_ready=1.
  - Byte packing is big-endian: the first byte of each word lands in [31:24], the last in [7:0].
  - Accepting the 4th byte of a word, or the final byte of the transfer, loads the word register and moves to PUSH on the next edge.
  - For a final partial word, mem_wr_mask sets 1 for each unfilled lane; e.g. 1 byte left gives 4'b0111. Otherwise the mask is 4'b0000.
- PUSH:
  - byte_ready=0.
  - mem_wr_en = !mem_wr_full, combinational from registered state.
  - On the strobe: burst_cnt increments.
  - If burst_cnt+1 == BURST_WORDS or bytes_left == 0, go to CMD; else return to FILL.
  - Latency: 4th byte accepted at edge N gives mem_wr_en high in cycle N+1 when not full.
- CMD:
  - mem_cmd_bl = burst_cnt-1 and mem_cmd_byte_addr = addr are stable throughout CMD.
  - mem_cmd_en = !mem_cmd_full, combinational.
  - On the strobe: addr += 4*burst_cnt, burst_cnt=0; then go to FILL if bytes_left>0, else DRAIN.
  - A command is never issued before all of its words are in the write FIFO.
- DRAIN: wait for mem_wr_empty=1, then go to DONE.
- DONE: done=1. A new start restarts the transfer and clears done.
- start outside IDLE/DONE is ignored.
- Any state except IDLE: mem_wr_underrun or mem_wr_error moves to ERR on the next edge.
- ERR: error=1; all strobes and byte_ready held at 0; only rst exits.
- Simultaneous events:
  - Error flags take priority over every other transition.
  - Full flags stall the strobe indefinitely; no data is lost.
- The final burst may be shorter than BURST_WORDS; bl reflects the actual word count.
- Reset mid-operation returns to IDLE immediately. MIG FIFOs are not flushed; the system is responsible for reset sequencing.
- Width rules:
  - bytes_left is $clog2(TOTAL_BYTES+1) bits.
  - burst_cnt is 7 bits.
  - The address adder is 30 bits and wraps modulo 2^30 with no flag.

Decomposition:
- Shared definitions header holds:
  - MIG instruction codes: MIG_WRITE=3'b000, MIG_READ=3'b001.
  - The state encoding localparams.
  - A BYTES_PER_WORD=4 constant.
- One sub-module, byte_word_packer, owns the byte-lane shift register, lane count and mask generation. It exposes word_valid, word, mask and a clear input.
- The FSM, counters and MIG strobes stay in mem_burst_writer.

Test Plan:
1. Full-burst transfer: TOTAL_BYTES=8, BURST_WORDS=2, bytes 01..08, no backpressure -> two mem_wr_en with 32'h01020304 and 32'h05060708, mask 0; then one mem_cmd_en with bl=1, addr=BASE_ADDR; done after mem_wr_empty.
2. Partial word and short final burst: TOTAL_BYTES=9, BURST_WORDS=2 -> bursts at addr 0 (bl=1) and addr 8 (bl=0); last word 32'h09000000 with mask 4'b0111.
3. Write-FIFO backpressure: hold mem_wr_full=1 for 10 cycles during PUSH -> mem_wr_en stays 0 and byte_ready stays 0; word delivered unchanged on release.
4. Command-FIFO backpressure: hold mem_cmd_full=1 for 5 cycles during CMD -> no mem_cmd_en; bl and addr stable; exactly one command after release.
5. Error: pulse mem_wr_underrun mid-FILL -> error=1 next edge; no further strobes; cleared only by rst.
6. Reset mid-burst, then restart: rst after 3 bytes, then start with a fresh stream -> first command addr=BASE_ADDR, bl correct; a start issued while busy is ignored.
